// File: rtl/countdown_pkg.sv
// countdown_pkg: shared types and constants for the M:SS countdown timer.
//   state_t       : controller states (IDLE, RUN, PAUSE, EXPIRED)
//   SEG_0..SEG_9  : active-low 7-segment patterns, bit order gfedcba
//   SEG_BLANK     : all segments off
//   MAX_*         : largest legal value of each display digit
//   clamp_digit() : saturates a switch value to a digit limit
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1011000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] MAX_SEC   = 4'd9;
  localparam logic [2:0] MAX_SEC10 = 3'd5;
  localparam logic [3:0] MAX_MIN   = 4'd9;

  function automatic logic [3:0] clamp_digit(input logic [3:0] value,
                                             input logic [3:0] limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/seg7_dec.sv
// seg7_dec: combinational BCD digit to active-low 7-segment decoder.
//   digit : 4-bit value; 0..9 decode to a numeral, 10..15 blank
//   seg   : 7-bit pattern gfedcba, 0 = segment lit
module seg7_dec
  import countdown_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: M:SS countdown (9:59 max) on three active-low 7-seg digits.
//   CLK        : system clock
//   RST        : synchronous, active-high reset
//   LOAD       : level; load clamped SET_* digits and return to IDLE
//   START_STOP : debounced button level; rising edge starts/pauses/resumes,
//                or acknowledges expiry (restoring the last loaded value)
//   SET_MIN, SET_SEC10, SET_SEC : switch values, clamped to 9, 5, 9
//   HEX0/HEX1/HEX2 : seconds / tens-of-seconds / minutes, gfedcba active-low
//   RUNNING    : high while counting
//   DONE       : high once the count has reached 0:00
// Optional build macro COUNTDOWN_BLINK_EN: when defined, the expired 0:00
// display blinks at 1 Hz; otherwise it is shown steadily.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LOAD,
  input  logic       START_STOP,
  input  logic [3:0] SET_MIN,
  input  logic [2:0] SET_SEC10,
  input  logic [3:0] SET_SEC,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic       RUNNING,
  output logic       DONE
);

  localparam int              PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]   PRESC_MAX  = PW'(CLK_HZ - 1);
`ifdef COUNTDOWN_BLINK_EN
  localparam logic [PW-1:0]   PRESC_HALF = PW'(CLK_HZ / 2);
`endif

  state_t        state_q, state_d;
  logic [3:0]    min_q, min_d;
  logic [2:0]    sec10_q, sec10_d;
  logic [3:0]    sec_q, sec_d;
  logic [3:0]    rl_min_q, rl_min_d;
  logic [2:0]    rl_sec10_q, rl_sec10_d;
  logic [3:0]    rl_sec_q, rl_sec_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          start_prev_q;

  logic          start_edge;
  logic          value_zero;
  logic          tick;

  logic [3:0]    ld_min, ld_sec;
  logic [2:0]    ld_sec10;

  logic [3:0]    dec_min, dec_sec;
  logic [2:0]    dec_sec10;
  logic          borrow_sec10, borrow_min;
  logic          dec_zero;

  assign start_edge = START_STOP & ~start_prev_q;
  assign value_zero = (min_q == 4'd0) && (sec10_q == 3'd0) && (sec_q == 4'd0);
  assign tick       = (presc_q == PRESC_MAX);

  assign ld_min   = clamp_digit(SET_MIN, MAX_MIN);
  assign ld_sec10 = 3'(clamp_digit({1'b0, SET_SEC10}, {1'b0, MAX_SEC10}));
  assign ld_sec   = clamp_digit(SET_SEC, MAX_SEC);

  // Decrement with borrow: seconds wrap 0->9, tens wrap 0->5, minutes only
  // move when both lower digits borrow.
  assign borrow_sec10 = (sec_q == 4'd0);
  assign borrow_min   = borrow_sec10 && (sec10_q == 3'd0);
  assign dec_sec      = borrow_sec10 ? MAX_SEC : sec_q - 4'd1;
  assign dec_sec10    = !borrow_sec10        ? sec10_q
                      : (sec10_q == 3'd0)    ? MAX_SEC10
                      :                        sec10_q - 3'd1;
  assign dec_min      = borrow_min ? min_q - 4'd1 : min_q;
  assign dec_zero     = (dec_min == 4'd0) && (dec_sec10 == 3'd0) && (dec_sec == 4'd0);

  // Next-state and datapath. Priority is LOAD > start_edge > tick; a start
  // edge on a tick cycle pauses and suppresses that decrement.
  always_comb begin
    // NOTE: every signal written here gets its hold value first, so no branch
    // can leave one unassigned and infer a latch.
    state_d    = state_q;
    min_d      = min_q;
    sec10_d    = sec10_q;
    sec_d      = sec_q;
    rl_min_d   = rl_min_q;
    rl_sec10_d = rl_sec10_q;
    rl_sec_d   = rl_sec_q;
    presc_d    = presc_q;

    if (LOAD) begin
      min_d      = ld_min;
      sec10_d    = ld_sec10;
      sec_d      = ld_sec;
      rl_min_d   = ld_min;
      rl_sec10_d = ld_sec10;
      rl_sec_d   = ld_sec;
      presc_d    = '0;
      state_d    = IDLE;
    end else if (start_edge) begin
      case (state_q)
        IDLE: begin
          // A zero value never enters RUN, so a tick can never see 0:00.
          if (!value_zero) begin
            state_d = RUN;
            presc_d = '0;
          end
        end
        RUN:   state_d = PAUSE;   // prescaler holds the partial second
        PAUSE: state_d = RUN;
        EXPIRED: begin
          state_d = IDLE;
          min_d   = rl_min_q;
          sec10_d = rl_sec10_q;
          sec_d   = rl_sec_q;
          presc_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        RUN: begin
          if (tick) begin
            presc_d = '0;
            min_d   = dec_min;
            sec10_d = dec_sec10;
            sec_d   = dec_sec;
            if (dec_zero) state_d = EXPIRED;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
`ifdef COUNTDOWN_BLINK_EN
        EXPIRED: presc_d = tick ? '0 : presc_q + PW'(1);
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (RST) begin
      state_q      <= IDLE;
      min_q        <= '0;
      sec10_q      <= '0;
      sec_q        <= '0;
      rl_min_q     <= '0;
      rl_sec10_q   <= '0;
      rl_sec_q     <= '0;
      presc_q      <= '0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      min_q        <= min_d;
      sec10_q      <= sec10_d;
      sec_q        <= sec_d;
      rl_min_q     <= rl_min_d;
      rl_sec10_q   <= rl_sec10_d;
      rl_sec_q     <= rl_sec_d;
      presc_q      <= presc_d;
      start_prev_q <= START_STOP;
    end
  end

  assign RUNNING = (state_q == RUN);
  assign DONE    = (state_q == EXPIRED);

  logic [6:0] seg_sec, seg_sec10, seg_min;
  logic       blank;

  seg7_dec u_dec_sec   (.digit(sec_q),            .seg(seg_sec));
  seg7_dec u_dec_sec10 (.digit({1'b0, sec10_q}),  .seg(seg_sec10));
  seg7_dec u_dec_min   (.digit(min_q),            .seg(seg_min));

`ifdef COUNTDOWN_BLINK_EN
  // Second half of each prescaler period blanks the expired display.
  assign blank = (state_q == EXPIRED) && (presc_q >= PRESC_HALF);
`else
  assign blank = 1'b0;
`endif

  assign HEX0 = blank ? SEG_BLANK : seg_sec;
  assign HEX1 = blank ? SEG_BLANK : seg_sec10;
  assign HEX2 = blank ? SEG_BLANK : seg_min;

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed scenarios followed by a randomized phase, all
// compared each cycle against a reference model that tracks the remaining
// time as a plain count of seconds.
module tb_countdown_timer;

  localparam int CLK_HZ = 4;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_EXP   = 3;

  logic       CLK = 1'b0;
  logic       RST;
  logic       LOAD;
  logic       START_STOP;
  logic [3:0] SET_MIN;
  logic [2:0] SET_SEC10;
  logic [3:0] SET_SEC;
  logic [6:0] HEX0, HEX1, HEX2;
  logic       RUNNING, DONE;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int   m_mode;
  int   m_rem;      // remaining seconds
  int   m_reload;   // seconds restored after expiry
  int   m_cnt;      // clock cycles into the current second
  logic m_prev;

  always #5 CLK = ~CLK;

  countdown_timer #(.CLK_HZ(CLK_HZ)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .LOAD       (LOAD),
    .START_STOP (START_STOP),
    .SET_MIN    (SET_MIN),
    .SET_SEC10  (SET_SEC10),
    .SET_SEC    (SET_SEC),
    .HEX0       (HEX0),
    .HEX1       (HEX1),
    .HEX2       (HEX2),
    .RUNNING    (RUNNING),
    .DONE       (DONE)
  );

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1011000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    logic start_edge;
    start_edge = START_STOP && !m_prev;
    m_prev     = START_STOP;
    if (RST) begin
      m_mode = M_IDLE; m_rem = 0; m_reload = 0; m_cnt = 0; m_prev = 1'b0;
    end else if (LOAD) begin
      m_rem    = min_int(int'(SET_MIN), 9) * 60 + min_int(int'(SET_SEC10), 5) * 10
               + min_int(int'(SET_SEC), 9);
      m_reload = m_rem;
      m_mode   = M_IDLE;
      m_cnt    = 0;
    end else if (start_edge) begin
      if (m_mode == M_IDLE) begin
        if (m_rem != 0) begin m_mode = M_RUN; m_cnt = 0; end
      end else if (m_mode == M_RUN) begin
        m_mode = M_PAUSE;
      end else if (m_mode == M_PAUSE) begin
        m_mode = M_RUN;
      end else begin
        m_mode = M_IDLE; m_rem = m_reload; m_cnt = 0;
      end
    end else if (m_mode == M_RUN) begin
      m_cnt++;
      if (m_cnt == CLK_HZ) begin
        m_cnt = 0;
        m_rem--;
        if (m_rem == 0) m_mode = M_EXP;
      end
    end
`ifdef COUNTDOWN_BLINK_EN
    else if (m_mode == M_EXP) begin
      m_cnt = (m_cnt + 1) % CLK_HZ;
    end
`endif
  endtask

  task automatic check_model();
    logic [6:0] e0, e1, e2;
    e2 = seg_of(m_rem / 60);
    e1 = seg_of((m_rem % 60) / 10);
    e0 = seg_of(m_rem % 10);
`ifdef COUNTDOWN_BLINK_EN
    if (m_mode == M_EXP && m_cnt >= CLK_HZ / 2) begin
      e0 = 7'b1111111; e1 = 7'b1111111; e2 = 7'b1111111;
    end
`endif
    check("model_hex0", HEX0, e0);
    check("model_hex1", HEX1, e1);
    check("model_hex2", HEX2, e2);
    check("model_running", {6'd0, RUNNING}, {6'd0, (m_mode == M_RUN)});
    check("model_done", {6'd0, DONE}, {6'd0, (m_mode == M_EXP)});
  endtask

  // Inputs change only at the falling edge; outputs are checked there too.
  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge CLK);
      model_step();
      @(negedge CLK);
      check_model();
    end
  endtask

  task automatic load_value(input logic [3:0] mn, input logic [2:0] s10, input logic [3:0] s);
    LOAD = 1'b1; START_STOP = 1'b0;
    SET_MIN = mn; SET_SEC10 = s10; SET_SEC = s;
    cycle(1);
    LOAD = 1'b0;
  endtask

  initial begin
    int blanks;
    m_mode = M_IDLE; m_rem = 0; m_reload = 0; m_cnt = 0; m_prev = 1'b0;
    RST = 1'b1; LOAD = 1'b0; START_STOP = 1'b0;
    SET_MIN = 4'd0; SET_SEC10 = 3'd0; SET_SEC = 4'd0;

    // Reset shows 0:00, idle.
    cycle(2);
    check("reset_hex0", HEX0, 7'b1000000);
    check("reset_hex1", HEX1, 7'b1000000);
    check("reset_hex2", HEX2, 7'b1000000);
    check("reset_running", {6'd0, RUNNING}, 7'd0);
    check("reset_done", {6'd0, DONE}, 7'd0);
    RST = 1'b0;
    cycle(1);

    // 1:00 -> 0:59 exactly CLK_HZ cycles after the start edge (minute borrow).
    load_value(4'd1, 3'd0, 4'd0);
    START_STOP = 1'b1;
    cycle(1);
    check("start_running", {6'd0, RUNNING}, 7'd1);
    cycle(CLK_HZ - 1);
    check("pre_tick_hex0", HEX0, 7'b1000000);
    cycle(1);
    check("borrow_hex2", HEX2, 7'b1000000);
    check("borrow_hex1", HEX1, 7'b0010010);
    check("borrow_hex0", HEX0, 7'b0010000);

    // 0:02 expires after 8 cycles; a start edge restores 0:02.
    load_value(4'd0, 3'd0, 4'd2);
    START_STOP = 1'b1;
    cycle(1);
    cycle(2 * CLK_HZ);
    check("expire_hex0", HEX0, 7'b1000000);
    check("expire_hex2", HEX2, 7'b1000000);
    check("expire_done", {6'd0, DONE}, 7'd1);
    check("expire_running", {6'd0, RUNNING}, 7'd0);
    START_STOP = 1'b0;
    cycle(1);
    check("done_held", {6'd0, DONE}, 7'd1);
    START_STOP = 1'b1;
    cycle(1);
    check("restore_done", {6'd0, DONE}, 7'd0);
    check("restore_hex0", HEX0, 7'b0100100);

    // Pause preserves the partial second.
    load_value(4'd0, 3'd0, 4'd5);
    START_STOP = 1'b1;
    cycle(1);
    START_STOP = 1'b0;
    cycle(2);
    START_STOP = 1'b1;
    cycle(1);
    check("pause_running", {6'd0, RUNNING}, 7'd0);
    START_STOP = 1'b0;
    cycle(10);
    check("paused_hex0", HEX0, 7'b0010010);
    START_STOP = 1'b1;
    cycle(1);
    check("resume_running", {6'd0, RUNNING}, 7'd1);
    cycle(1);
    check("resume_plus1_hex0", HEX0, 7'b0010010);
    cycle(1);
    check("resume_plus2_hex0", HEX0, 7'b0011001);

    // Out-of-range switches clamp to 9:59; LOAD beats a coincident start edge.
    load_value(4'd12, 3'd7, 4'd15);
    check("clamp_hex2", HEX2, 7'b0010000);
    check("clamp_hex1", HEX1, 7'b0010010);
    check("clamp_hex0", HEX0, 7'b0010000);
    LOAD = 1'b1; START_STOP = 1'b1;
    cycle(1);
    check("load_beats_start", {6'd0, RUNNING}, 7'd0);
    LOAD = 1'b0;
    cycle(1);
    check("no_edge_while_high", {6'd0, RUNNING}, 7'd0);

    // A zero value cannot be started.
    load_value(4'd0, 3'd0, 4'd0);
    START_STOP = 1'b1;
    cycle(1);
    check("zero_start_running", {6'd0, RUNNING}, 7'd0);
    check("zero_start_hex0", HEX0, 7'b1000000);
    START_STOP = 1'b0;
    cycle(1);

`ifdef COUNTDOWN_BLINK_EN
    // Expired display is blank for half of every CLK_HZ cycles.
    load_value(4'd0, 3'd0, 4'd1);
    START_STOP = 1'b1;
    cycle(1);
    START_STOP = 1'b0;
    cycle(CLK_HZ);
    blanks = 0;
    for (int k = 0; k < CLK_HZ; k++) begin
      cycle(1);
      if (HEX0 == 7'b1111111) blanks++;
    end
    check("blink_count", 7'(blanks), 7'(CLK_HZ / 2));
`else
    blanks = 0;
`endif

    // Randomized phase: mostly short loads so runs expire and get restored.
    for (int i = 0; i < 2500; i++) begin
      RST  = ($urandom_range(0, 599) == 0);
      LOAD = ($urandom_range(0, 59) == 0);
      if (LOAD) begin
        SET_MIN   = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
        SET_SEC10 = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
        SET_SEC   = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 9) == 0) START_STOP = ~START_STOP;
      cycle(1);
    end
    RST = 1'b0; LOAD = 1'b0;
    cycle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Minutes/seconds countdown timer (M:SS, 9:59 max) showing its value on three active-low 7-segment digits.
- Runs the opposite direction to the team's up-counting seconds display.
- Loaded from board switches; started, paused and resumed by a single pushbutton pulse.
- Signals expiry to downstream logic (buzzer/LED) via DONE.

Parameters:
- CLK_HZ, 50_000_000, clock frequency; one count tick every CLK_HZ cycles (benches use a small value, e.g. 4).

Ports:
- CLK  in  1  system clock, 50 MHz.
- RST  in  1  synchronous, active-high reset.
- LOAD  in  1  level; load SET_* into digits, go to IDLE.
- START_STOP  in  1  already-debounced, synchronized button level; rising edge is the command.
- SET_MIN  in  4  minutes digit to load.
- SET_SEC10  in  3  tens-of-seconds digit to load.
- SET_SEC  in  4  seconds digit to load.
- HEX0  out  7  seconds digit, gfedcba, 0 = segment lit.
- HEX1  out  7  tens-of-seconds digit.
- HEX2  out  7  minutes digit.
- RUNNING  out  1  high in RUN.
- DONE  out  1  high in EXPIRED.

Behaviour:
- Everything is registered on posedge CLK. HEX outputs are combinational decodes of the digit registers.
- Reset: min/sec10/sec = 0, prescaler = 0, start_prev = 0, state = IDLE, RUNNING = 0, DONE = 0. HEX0..2 therefore show 0:00.
- Edge detect: start_edge = START_STOP & ~start_prev; start_prev <= START_STOP every cycle.
- Load clamp: SET_SEC > 9 loads 9; SET_SEC10 > 5 loads 5; SET_MIN > 9 loads 9. The clamped value is also saved in a reload register.
- State machine has four states: IDLE, RUN, PAUSE, EXPIRED.
- Priority: RST > LOAD > start_edge > tick.
- LOAD (any state): load the clamped digits, state = IDLE, prescaler = 0.
- IDLE + start_edge:
  - value != 0:00 → RUN, prescaler = 0.
  - value == 0:00 → ignored, stay in IDLE.
- RUN + start_edge → PAUSE. The prescaler holds its value, so the partial second is preserved on resume.
- PAUSE + start_edge → RUN; the prescaler continues from the held value.
- EXPIRED + start_edge → IDLE, digits restored from the reload register.
- Tick: in RUN only, when prescaler == CLK_HZ-1. At that edge the prescaler goes to 0 and the value decrements; otherwise the prescaler increments.
- First decrement occurs exactly CLK_HZ cycles after the edge that entered RUN from IDLE.
- Decrement with borrow:
  - sec 0 → 9, borrowing from sec10.
  - sec10 0 → 5, borrowing from min.
  - min only decrements when borrowed from.
- Expiry: a tick that makes the value 0:00 also moves state to EXPIRED on the same edge. DONE = 1 from the next cycle and stays high until LOAD, start_edge or RST.
- A tick can never occur at 0:00 because RUN is never entered with a zero value.
- A start_edge in the same cycle as a tick (RUN): PAUSE wins and no decrement happens.
- Decoder patterns 0–9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1011000, 0000000, 0010000. Any other code gives 1111111 (blank); no X outputs.

Optional Feature:
- Macro: COUNTDOWN_BLINK_EN.
- Defined: in EXPIRED the prescaler free-runs and wraps at CLK_HZ-1. HEX0..2 are forced to 1111111 while prescaler >= CLK_HZ/2, giving a 1 Hz blink of 0:00. The prescaler is cleared on entering EXPIRED. DONE is unaffected.
- Undefined: EXPIRED shows a steady 0:00; the prescaler holds at 0.

Decomposition:
- Package countdown_pkg holds:
  - the state enum (IDLE, RUN, PAUSE, EXPIRED);
  - the SEG_0..SEG_9 and SEG_BLANK 7-bit constants;
  - the digit limits MAX_SEC = 9, MAX_SEC10 = 5, MAX_MIN = 9.
- One sub-module, seg7_dec: 4-bit digit in, 7-bit active-low pattern out, purely combinational. It is instantiated three times.

Test Plan (CLK_HZ = 4):
- Reset → HEX2/HEX1/HEX0 = 1000000 ×3, RUNNING = 0, DONE = 0.
- LOAD with SET=1:00, then START_STOP 0→1 → RUNNING = 1. Four cycles later the display reads 0:59: HEX2 = 1000000, HEX1 = 0010010, HEX0 = 0010000.
- LOAD 0:02, start → after 8 cycles the display reads 0:00, state is EXPIRED and DONE = 1. A further start edge → IDLE showing 0:02, DONE = 0.
- LOAD 0:05, start, pause after 2 cycles, hold paused for 10 cycles, resume → the decrement to 0:04 lands 2 cycles after resume.
- LOAD with SET_MIN = 12, SET_SEC10 = 7, SET_SEC = 15 → display reads 9:59. Then LOAD and start_edge in the same cycle → stays IDLE.
- LOAD 0:00, start → remains IDLE, RUNNING = 0. Separately, with COUNTDOWN_BLINK_EN defined, EXPIRED shows HEX = 1111111 for 2 of every 4 cycles.
